// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: execution controller for the single-cycle core.
// Gates PC update / RF write per cycle, provides run / halt / single-step
// control, stalls IN instructions until switch data is valid, detects the
// halt instruction and keeps cycle / retired-instruction counters.
// Optional breakpoint support is compiled in when BREAKPOINT_EN is defined.
module cpu_exec_ctrl #(
  parameter logic [31:0] HALT_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  input  logic             sw_valid_i,
  input  logic [31:0]      bp_addr_i,
  output logic             pc_en_o,
  output logic             rf_we_o,
  output logic             sw_ack_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             bp_hit_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_STEP    = 3'd2,
    S_WAIT_IN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             step_q;
  logic             step_mode_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic step_rise;
  logic is_in;
  logic is_halt;
  logic active;
  logic commit;
  logic bp_stop;
  logic bp_match;

  assign step_rise = step_i & ~step_q;
  assign is_in     = instr_i[29] & (instr_i[28:27] == 2'b01);
  assign is_halt   = (instr_i == HALT_INSTR);
  assign active    = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_WAIT_IN);

`ifdef BREAKPOINT_EN
  logic bp_armed_q;

  assign bp_match = bp_armed_q && (pc_i == bp_addr_i);
  assign bp_hit_o = bp_stop & rst_i;

  // Disarm on a breakpoint stop; re-arm on the next commit so the
  // instruction at the breakpoint executes on resume.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bp_armed_q <= 1'b1;
    end else if (bp_stop) begin
      bp_armed_q <= 1'b0;
    end else if (commit) begin
      bp_armed_q <= 1'b1;
    end
  end
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign bp_hit_o  = 1'b0;
  assign unused_bp = ^{pc_i, bp_addr_i, bp_stop};
`endif

  // Next-state and commit decision; RUN/STEP/WAIT_IN share one priority order.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    bp_stop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!halt_i) begin
          if (run_i) begin
            state_d = S_RUN;
          end else if (step_rise) begin
            state_d = S_STEP;
          end
        end
      end
      S_RUN, S_STEP, S_WAIT_IN: begin
        if (halt_i) begin
          state_d = S_IDLE;
        end else if (bp_match && (state_q == S_RUN)) begin
          bp_stop = 1'b1;
          state_d = S_IDLE;
        end else if (is_halt) begin
          state_d = S_DONE;
        end else if (is_in && !sw_valid_i) begin
          state_d = S_WAIT_IN;
        end else begin
          commit = 1'b1;
          case (state_q)
            S_RUN:   state_d = S_RUN;
            S_STEP:  state_d = S_IDLE;
            default: state_d = step_mode_q ? S_IDLE : S_RUN;
          endcase
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, step edge register, step-mode latch and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_i;
      if ((state_d == S_WAIT_IN) && (state_q != S_WAIT_IN)) begin
        step_mode_q <= (state_q == S_STEP);
      end
      if (active) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (commit) begin
        instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is asserted so a reset mid-stall never commits.
  assign pc_en_o     = commit & rst_i;
  assign rf_we_o     = instr_i[29] & pc_en_o;
  assign sw_ack_o    = is_in & pc_en_o;
  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Scoreboard bench for cpu_exec_ctrl: the driver pushes one expected
// response per cycle; the monitor pops and compares on the falling edge.
module tb_cpu_exec_ctrl;

  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, run_i, halt_i, step_i, sw_valid_i;
  logic [31:0]   instr_i, pc_i, bp_addr_i;
  logic          pc_en_o, rf_we_o, sw_ack_o, bp_hit_o;
  logic [2:0]    state_o;
  logic [CW-1:0] cycle_cnt_o, instr_cnt_o;

  typedef struct {
    string       nm;
    bit          pe, we, ack, bp, chk;
    int unsigned st, cyc, ins;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [31:0] I_ALU  = 32'h2000_0005;
  localparam logic [31:0] I_IN   = 32'h2800_0000;
  localparam logic [31:0] I_HALT = 32'h0000_0000;

  cpu_exec_ctrl #(.HALT_INSTR(32'h0000_0000), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .instr_i(instr_i), .pc_i(pc_i), .sw_valid_i(sw_valid_i), .bp_addr_i(bp_addr_i),
    .pc_en_o(pc_en_o), .rf_we_o(rf_we_o), .sw_ack_o(sw_ack_o), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o), .bp_hit_o(bp_hit_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void cmp(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic e(input string nm, input bit pe, input bit we, input bit ack,
                   input int unsigned st, input bit bp = 0, input bit chk = 0,
                   input int unsigned cyc = 0, input int unsigned ins = 0);
    exp_t x;
    x.nm = nm; x.pe = pe; x.we = we; x.ack = ack; x.st = st; x.bp = bp;
    x.chk = chk; x.cyc = cyc; x.ins = ins;
    q.push_back(x);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [CW-1:0] cy, in;
      x = q.pop_front();
      cy = CW'(x.cyc);
      in = CW'(x.ins);
      cmp(x.nm, "pc_en", {31'd0, pc_en_o}, {31'd0, x.pe});
      cmp(x.nm, "rf_we", {31'd0, rf_we_o}, {31'd0, x.we});
      cmp(x.nm, "sw_ack", {31'd0, sw_ack_o}, {31'd0, x.ack});
      cmp(x.nm, "bp_hit", {31'd0, bp_hit_o}, {31'd0, x.bp});
      cmp(x.nm, "state", {29'd0, state_o}, x.st);
      if (x.chk) begin
        cmp(x.nm, "cycle_cnt", 32'(cycle_cnt_o), 32'(cy));
        cmp(x.nm, "instr_cnt", 32'(instr_cnt_o), 32'(in));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 0; run_i = 0; halt_i = 0; step_i = 0; sw_valid_i = 0;
    instr_i = I_ALU; pc_i = 32'd100; bp_addr_i = 32'd3;

    // Reset and continuous run
    tick(); e("reset", 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); rst_i = 1; run_i = 1; e("t1_idle", 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(); e("t1_run", 1, 1, 0, 1, 0, 1, k - 1, k - 1);
    end
    tick(); halt_i = 1; e("t1_halt", 0, 0, 0, 1, 0, 1, 10, 10);
    tick(); halt_i = 0; run_i = 0; e("t1_stop", 0, 0, 0, 0, 0, 1, 11, 10);

    // Single step with held level
    tick(); rst_i = 0; e("t2_rst", 0, 0, 0, 0);
    tick(); rst_i = 1; e("t2_clr", 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); step_i = 1; e("t2_s1", 0, 0, 0, 0);
    tick(); e("t2_s2", 1, 1, 0, 2);
    for (int k = 0; k < 3; k++) begin
      tick(); e("t2_hold", 0, 0, 0, 0);
    end
    tick(); step_i = 0; e("t2_drop", 0, 0, 0, 0, 0, 1, 1, 1);
    tick(); step_i = 1; e("t2_s3", 0, 0, 0, 0);
    tick(); e("t2_s4", 1, 1, 0, 2);
    tick(); step_i = 0; e("t2_end", 0, 0, 0, 0, 0, 1, 2, 2);

    // Switch-input stall
    tick(); run_i = 1; e("t3_idle", 0, 0, 0, 0);
    tick(); instr_i = I_IN; e("t3_in", 0, 0, 0, 1, 0, 1, 2, 2);
    for (int k = 0; k < 4; k++) begin
      tick(); e("t3_wait", 0, 0, 0, 3, 0, 1, 3 + k, 2);
    end
    tick(); sw_valid_i = 1; e("t3_ack", 1, 1, 1, 3, 0, 1, 7, 2);
    tick(); sw_valid_i = 0; instr_i = I_ALU; e("t3_back", 1, 1, 0, 1, 0, 1, 8, 3);

    // Halt instruction and DONE
    tick(); instr_i = I_HALT; e("t4_halt", 0, 0, 0, 1, 0, 1, 9, 4);
    tick(); run_i = 0; step_i = 1; e("t4_done1", 0, 0, 0, 4, 0, 1, 10, 4);
    tick(); run_i = 1; step_i = 0; halt_i = 1; e("t4_done2", 0, 0, 0, 4, 0, 1, 10, 4);
    tick(); halt_i = 0; step_i = 1; e("t4_done3", 0, 0, 0, 4);
    tick(); rst_i = 0; step_i = 0; run_i = 0; e("t4_rst", 0, 0, 0, 4);
    tick(); rst_i = 1; instr_i = I_ALU; e("t4_clr", 0, 0, 0, 0, 0, 1, 0, 0);

    // halt_i in WAIT_IN, then reset in WAIT_IN
    tick(); run_i = 1; e("t5_idle", 0, 0, 0, 0);
    tick(); instr_i = I_IN; e("t5_in", 0, 0, 0, 1);
    tick(); e("t5_wait", 0, 0, 0, 3);
    tick(); halt_i = 1; sw_valid_i = 1; e("t5_halt", 0, 0, 0, 3);
    tick(); halt_i = 0; sw_valid_i = 0; run_i = 0; e("t5_idle2", 0, 0, 0, 0, 0, 1, 3, 0);
    tick(); run_i = 1; e("t5_idle3", 0, 0, 0, 0);
    tick(); e("t5_in2", 0, 0, 0, 1);
    tick(); sw_valid_i = 1; rst_i = 0; e("t5_rstw", 0, 0, 0, 3);
    tick(); rst_i = 1; sw_valid_i = 0; run_i = 0; instr_i = I_ALU; e("t5_clr", 0, 0, 0, 0, 0, 1, 0, 0);

    // run_i held while halt_i asserted
    tick(); run_i = 1; halt_i = 1; e("hr_1", 0, 0, 0, 0);
    tick(); e("hr_2", 0, 0, 0, 0);
    tick(); halt_i = 0; e("hr_3", 0, 0, 0, 0);
    tick(); e("hr_run", 1, 1, 0, 1);
    tick(); halt_i = 1; e("hr_stop", 0, 0, 0, 1);
    tick(); halt_i = 0; run_i = 0; e("hr_idle", 0, 0, 0, 0);

    // Breakpoint at PC 3
    tick(); rst_i = 0; e("t6_rst", 0, 0, 0, 0);
    tick(); rst_i = 1; run_i = 1; pc_i = 0; e("t6_idle", 0, 0, 0, 0);
    tick(); e("t6_pc0", 1, 1, 0, 1);
    tick(); pc_i = 1; e("t6_pc1", 1, 1, 0, 1);
    tick(); pc_i = 2; e("t6_pc2", 1, 1, 0, 1);
`ifdef BREAKPOINT_EN
    tick(); pc_i = 3; e("t6_bp", 0, 0, 0, 1, 1);
    tick(); run_i = 0; e("t6_stopped", 0, 0, 0, 0, 0);
    tick(); run_i = 1; e("t6_resume", 0, 0, 0, 0);
    tick(); e("t6_pc3", 1, 1, 0, 1, 0);
    tick(); pc_i = 4; e("t6_pc4", 1, 1, 0, 1);
    tick(); pc_i = 3; e("t6_bp2", 0, 0, 0, 1, 1);
    tick(); run_i = 0; e("t6_end", 0, 0, 0, 0);
`else
    tick(); pc_i = 3; e("t6_pc3", 1, 1, 0, 1, 0);
    tick(); pc_i = 4; e("t6_pc4", 1, 1, 0, 1, 0);
    tick(); pc_i = 3; e("t6_pc3b", 1, 1, 0, 1, 0);
    tick(); halt_i = 1; e("t6_halt", 0, 0, 0, 1);
    tick(); halt_i = 0; run_i = 0; e("t6_end", 0, 0, 0, 0);
`endif

    // Counter wrap at 2^CW
    tick(); rst_i = 0; pc_i = 32'd100; e("w_rst", 0, 0, 0, 0);
    tick(); rst_i = 1; run_i = 1; e("w_idle", 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      tick(); e("w_run", 1, 1, 0, 1, 0, 1, k - 1, k - 1);
    end
    tick(); halt_i = 1; e("w_halt", 0, 0, 0, 1, 0, 1, 18, 18);
    tick(); halt_i = 0; run_i = 0; e("w_end", 0, 0, 0, 0, 0, 1, 19, 18);

    tick();
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
